// File: rtl/tda_sched_pkg.sv
// Shared types and default widths for the TDA job scheduling blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tda_sched_pkg;

  localparam int SCHED_ID_W    = 2;
  localparam int SCHED_SIMP_W  = 12;
  localparam int SCHED_PAIR_W  = 10;
  localparam int SCHED_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RELEASE,
    ST_WAIT,
    ST_RESP
  } sched_state_t;

  // Result returned to a requester: owner tag, pair count, watchdog abort flag.
  typedef struct packed {
    logic [SCHED_ID_W-1:0]   id;
    logic [SCHED_PAIR_W-1:0] num_pairs;
    logic                    timeout;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    pick,
  output logic               found
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx > NUM_REQ - 1) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/homology_job_scheduler.sv
// Shares one homology reduction engine between NUM_REQ requesters with round-robin grants and a watchdog.
// Latency: req_ready 1 cycle after req_valid, start pulse at +2, rsp_valid 1 cycle after completion/timeout.
// Backpressure: rsp_* held stable until rsp_ready; no new grant while a response is pending.
module homology_job_scheduler
  import tda_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = SCHED_ID_W,
  parameter int SIMP_W  = SCHED_SIMP_W,
  parameter int PAIR_W  = SCHED_PAIR_W,
  parameter int TIMEOUT = SCHED_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*SIMP_W-1:0] req_num_simplices,
  input  logic [NUM_REQ*2-1:0]    req_max_dim,
  output logic                    eng_enable,
  output logic                    eng_compute_start,
  output logic [SIMP_W-1:0]       eng_num_simplices,
  output logic [1:0]              eng_max_dimension,
  output logic [ID_W-1:0]         eng_sel,
  input  logic                    eng_complete,
  input  logic [PAIR_W-1:0]       eng_num_pairs,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PAIR_W-1:0]       rsp_num_pairs,
  output logic                    rsp_timeout,
  output logic                    busy
);

  // Watchdog only has to reach TIMEOUT-1, so this width can never wrap.
  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t    state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt, pick;
  logic            found, grant, wd_expired;
  logic [WD_W-1:0] wd;
  rsp_t            rsp_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .pick  (pick),
    .found (found)
  );

  // Arbitration is sampled only while idle; enable gates new grants only.
  assign grant      = (state == ST_IDLE) && enable && found;
  assign ptr_nxt    = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

  assign eng_enable    = (state == ST_START) || (state == ST_RELEASE) || (state == ST_WAIT);
  assign busy          = (state != ST_IDLE);
  assign rsp_valid     = (state == ST_RESP);
  assign rsp_id        = rsp_q.id;
  assign rsp_num_pairs = rsp_q.num_pairs;
  assign rsp_timeout   = rsp_q.timeout;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant) state_nxt = ST_START;
      ST_START:   state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_WAIT;
      ST_WAIT:    if (eng_complete || wd_expired) state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping: one-cycle ready pulse, job latch, pointer advance, start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready         <= '0;
      eng_compute_start <= 1'b0;
      eng_num_simplices <= '0;
      eng_max_dimension <= '0;
      eng_sel           <= '0;
      ptr               <= '0;
    end else begin
      req_ready         <= '0;
      eng_compute_start <= (state == ST_START);
      if (grant) begin
        req_ready         <= NUM_REQ'(1) << pick;
        eng_num_simplices <= req_num_simplices[pick*SIMP_W +: SIMP_W];
        eng_max_dimension <= req_max_dim[pick*2 +: 2];
        eng_sel           <= pick;
        ptr               <= ptr_nxt;
      end
    end
  end

  // Watchdog: cleared once the start pulse is released, counts while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (state == ST_RELEASE) begin
      wd <= '0;
    end else if ((state == ST_WAIT) && !eng_complete && !wd_expired) begin
      wd <= wd + 1'b1;
    end
  end

  // Response capture; completion takes priority over a simultaneous timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else if (state == ST_WAIT) begin
      if (eng_complete) begin
        rsp_q.id        <= eng_sel;
        rsp_q.num_pairs <= eng_num_pairs;
        rsp_q.timeout   <= 1'b0;
      end else if (wd_expired) begin
        rsp_q.id        <= eng_sel;
        rsp_q.num_pairs <= '0;
        rsp_q.timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_homology_job_scheduler.sv
// Directed bench for homology_job_scheduler with a scripted engine model.
// Latency: checks grant, start pulse and response timing cycle by cycle.
// Backpressure: exercises a held response with competing requests.
module tb_homology_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int SIMP_W  = 12;
  localparam int PAIR_W  = 10;
  localparam int TIMEOUT = 100;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*SIMP_W-1:0] req_num_simplices;
  logic [NUM_REQ*2-1:0]      req_max_dim;
  logic                      eng_enable;
  logic                      eng_compute_start;
  logic [SIMP_W-1:0]         eng_num_simplices;
  logic [1:0]                eng_max_dimension;
  logic [ID_W-1:0]           eng_sel;
  logic                      eng_complete;
  logic [PAIR_W-1:0]         eng_num_pairs;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [PAIR_W-1:0]         rsp_num_pairs;
  logic                      rsp_timeout;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;

  homology_job_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .SIMP_W  (SIMP_W),
    .PAIR_W  (PAIR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_num_simplices (req_num_simplices),
    .req_max_dim       (req_max_dim),
    .eng_enable        (eng_enable),
    .eng_compute_start (eng_compute_start),
    .eng_num_simplices (eng_num_simplices),
    .eng_max_dimension (eng_max_dimension),
    .eng_sel           (eng_sel),
    .eng_complete      (eng_complete),
    .eng_num_pairs     (eng_num_pairs),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_id            (rsp_id),
    .rsp_num_pairs     (rsp_num_pairs),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One complete job: grant, start pulse, scripted completion after 'delay' WAIT cycles
  // (negative = never), optional response backpressure, then handshake.
  task automatic do_job(input int exp_id, input int delay, input int pairs,
                        input int exp_pairs, input bit exp_to, input int exp_wait,
                        input bit clear_req, input int bp_cycles, input logic [3:0] bp_req);
    int n;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check("grant_onehot", req_ready, 32'(1) << exp_id);
    check("eng_sel", eng_sel, exp_id);
    check("eng_simplices", eng_num_simplices, 100 + 10 * exp_id);
    check("eng_dim", eng_max_dimension, exp_id ^ 2);
    check("start_low_at_grant", eng_compute_start, 0);
    if (clear_req) req_valid = '0;
    tick();
    check("ready_one_cycle", req_ready, 0);
    check("start_high", eng_compute_start, 1);
    tick();
    check("start_pulse_end", eng_compute_start, 0);
    check("eng_enable_wait", eng_enable, 1);
    n = 0;
    while (!rsp_valid && n < 200) begin
      if (n == delay) begin
        eng_complete  = 1'b1;
        eng_num_pairs = PAIR_W'(pairs);
      end
      tick();
      n++;
    end
    check("wait_cycles", n, exp_wait);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_pairs", rsp_num_pairs, exp_pairs);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("eng_enable_resp", eng_enable, 0);
    check("busy_resp", busy, 1);
    if (bp_cycles > 0) req_valid = bp_req;
    for (int i = 0; i < bp_cycles; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, exp_id);
      check("bp_pairs", rsp_num_pairs, exp_pairs);
      check("bp_no_grant", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready    = 1'b0;
    eng_complete = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("busy_idle", busy, 0);
    check("no_grant_on_hs", req_ready, 0);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    enable        = 1'b0;
    req_valid     = '0;
    eng_complete  = 1'b0;
    eng_num_pairs = '0;
    rsp_ready     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_num_simplices[i*SIMP_W +: SIMP_W] = SIMP_W'(100 + 10 * i);
      req_max_dim[i*2 +: 2]                 = 2'(i ^ 2);
    end
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_enable", eng_enable, 0);
    check("rst_start", eng_compute_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_simp", eng_num_simplices, 0);
    rst = 1'b0;
    tick();

    // enable low blocks grants
    req_valid = 4'b0001;
    tick();
    tick();
    check("disabled_no_grant", req_ready, 0);
    enable = 1'b1;

    // single job on requester 0
    do_job(0, 50, 37, 37, 1'b0, 51, 1'b1, 0, 4'b0000);

    // fairness from a fresh pointer
    do_reset();
    req_valid = 4'b1111;
    do_job(0, 10, 5, 5, 1'b0, 11, 1'b0, 0, 4'b0000);
    do_job(1, 10, 6, 6, 1'b0, 11, 1'b0, 0, 4'b0000);
    do_job(2, 10, 7, 7, 1'b0, 11, 1'b0, 0, 4'b0000);
    do_job(3, 10, 8, 8, 1'b0, 11, 1'b0, 0, 4'b0000);
    do_job(0, 10, 9, 9, 1'b0, 11, 1'b1, 0, 4'b0000);

    // timeout on requester 1, then 1 and 2 compete: 2 must win
    req_valid = 4'b0010;
    do_job(1, -1, 0, 0, 1'b1, 100, 1'b1, 0, 4'b0000);
    req_valid = 4'b0110;
    // completion on the last watchdog cycle beats the timeout
    do_job(2, 99, 55, 55, 1'b0, 100, 1'b1, 0, 4'b0000);

    // backpressure on requester 3's response while requester 1 waits
    req_valid = 4'b1000;
    do_job(3, 5, 9, 9, 1'b0, 6, 1'b1, 20, 4'b0010);
    tick();
    check("grant_after_hs", req_ready, 4'b0010);
    do_job(1, 3, 4, 4, 1'b0, 4, 1'b1, 0, 4'b0000);

    // reset in the middle of WAIT
    req_valid = 4'b0100;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check("mid_grant", req_ready, 4'b0100);
    req_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_eng_enable", eng_enable, 0);
    check("arst_start", eng_compute_start, 0);
    check("arst_eng_sel", eng_sel, 0);
    check("arst_eng_simp", eng_num_simplices, 0);
    check("arst_eng_dim", eng_max_dimension, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_id", rsp_id, 0);
    check("arst_rsp_pairs", rsp_num_pairs, 0);
    check("arst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_no_rsp", rsp_valid, 0);
    // pointer back at 0: with 2 and 3 pending, 2 wins
    req_valid = 4'b1100;
    do_job(2, 0, 1, 1, 1'b0, 1, 1'b1, 0, 4'b0000);
    req_valid = 4'b1000;
    do_job(3, 2, 7, 7, 1'b0, 3, 1'b1, 0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/homology_job_scheduler.md
Name: homology_job_scheduler

Overview:
Shares one homology reduction engine between NUM_REQ requesters (e.g. per-channel TDA feature extractors). Round-robin arbitration selects a pending job, drives the engine's configuration and start, and supervises completion with a watchdog. It returns a tagged result over a valid/ready response channel. The block sits between the requester fabric and the engine; the simplex-data mux is driven from eng_sel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index, equal to clog2(NUM_REQ)
SIMP_W, 12, width of the simplex-count field
PAIR_W, 10, width of the persistence-pair count
TIMEOUT, 65535, maximum WAIT cycles before a job is aborted (at least 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
enable  in  1  global enable; when low, no new grants are issued
req_valid  in  NUM_REQ  per-requester job pending
req_ready  out  NUM_REQ  one-hot acceptance pulse to the granted requester
req_num_simplices  in  NUM_REQ*SIMP_W  packed simplex counts; requester i uses slice i
req_max_dim  in  NUM_REQ*2  packed maximum-dimension fields
eng_enable  out  1  engine enable
eng_compute_start  out  1  engine start
eng_num_simplices  out  SIMP_W  latched job simplex count
eng_max_dimension  out  2  latched job dimension
eng_sel  out  ID_W  owner of the current job, used as the data-mux select
eng_complete  in  1  engine computation_complete
eng_num_pairs  in  PAIR_W  engine pair count
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_id  out  ID_W  requester tag
rsp_num_pairs  out  PAIR_W  result pair count (0 on timeout)
rsp_timeout  out  1  job aborted by the watchdog
busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs are 0. The round-robin pointer is 0 and the watchdog is 0. Reset mid-job abandons the job and issues no response; eng_compute_start drops immediately.
- States: IDLE, START, RELEASE, WAIT, RESP.
- IDLE:
  - Condition: enable=1 and req_valid is nonzero.
  - Grant: the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Same edge: latch the winner's num_simplices, max_dim and ID into eng_* and eng_sel.
  - Same edge: req_ready[winner] is 1 for exactly this one cycle (registered), pointer <= winner+1 mod NUM_REQ, go to START.
  - A requester must hold req_valid until it sees req_ready.
- START: eng_compute_start=1 for exactly 1 cycle; go to RELEASE.
- RELEASE: eng_compute_start=0, which lets the engine leave its done state. Clear the watchdog and go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If eng_complete=1: capture eng_num_pairs, rsp_timeout=0, go to RESP.
  - Else if watchdog==TIMEOUT-1: rsp_num_pairs=0, rsp_timeout=1, go to RESP.
  - If complete arrives on the same cycle as the timeout, completion wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_num_pairs and rsp_timeout stay stable until rsp_ready=1.
  - On handshake: rsp_valid<=0 and go to IDLE. No new grant is issued on the handshake cycle, so back-to-back jobs are at least 1 idle cycle apart.
- eng_enable: 1 in START, RELEASE and WAIT; 0 otherwise.
- Latency: req_ready is seen one cycle after req_valid, start pulse at +2, rsp_valid at completion+1.
- enable dropping mid-job does not abort the job; it only blocks the next grant.
- req_valid changes outside IDLE are ignored. The arbitration sample point is the IDLE cycle only.
- The pointer advances only on a grant, never on a timeout alone. A timed-out requester still moves to the back of the order.
- Width rules: the pointer and ID are ID_W bits, and wrap uses explicit compare-to-NUM_REQ-1 (NUM_REQ need not be a power of 2). The watchdog is clog2(TIMEOUT+1) bits and is never allowed to wrap.

Decomposition:
- Shared package (tda_sched_pkg): the state enum, TIMEOUT default, SIMP_W and PAIR_W constants, and a response struct {id, num_pairs, timeout}.
- One sub-module, rr_arbiter: combinational pick of the next set bit after the pointer, plus a found flag. It is parameterised by NUM_REQ and reused by the other TDA accelerators.

Test Plan:
- Single job: req_valid=0001, num_simplices=100, dim=2; engine model completes after 50 cycles with pairs=37 -> req_ready[0] one cycle; start is a 1-cycle pulse; rsp_id=0, rsp_num_pairs=37, rsp_timeout=0.
- Fairness: req_valid=1111 held, each job completes in 10 cycles -> grant order 0,1,2,3,0; pointer wraps; no requester is granted twice before the others.
- Timeout: TIMEOUT=100, engine never completes -> rsp_valid exactly 100 cycles after RELEASE with rsp_timeout=1 and pairs=0; the next grant goes to the following requester.
- Completion/timeout tie: eng_complete rises in the cycle where watchdog=TIMEOUT-1 -> rsp_timeout=0 and pairs are captured.
- Backpressure: rsp_ready=0 for 20 cycles -> rsp_* stable and no new grant despite req_valid=0010; the grant follows 1 cycle after the handshake.
- Reset mid-WAIT: assert rst -> all outputs 0 asynchronously, pointer 0; after release, req_valid=1000 is granted normally.
